// File: rtl/ahb_err_slave_pkg.sv
// ahb_err_slave_pkg: HRESP encodings and FSM state type shared by the error slave.
package ahb_err_slave_pkg;
  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;
  localparam logic [1:0] HRESP_RETRY = 2'b10;
  localparam logic [1:0] HRESP_SPLIT = 2'b11;
  typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2, ST_DONE} state_t;
endpackage

// File: rtl/ahb_err_slave.sv
// ahb_err_slave: default AHB slave answering every transfer with ERROR (or OKAY/RAZ-WI), with error count/IRQ.
// First-fail address/direction capture is built only when AHB_ERR_SLAVE_CAPTURE_EN is defined.
module ahb_err_slave
  import ahb_err_slave_pkg::*;
#(
  parameter int WAIT_STATES = 0,
  parameter int RESP_MODE   = 0,
  parameter int ADDR_W      = 32,
  parameter int CNT_W       = 8
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSEL,
  input  logic [1:0]        HTRANS,
  input  logic              HREADY,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic              HWRITE,
  output logic              HREADYOUT,
  output logic [1:0]        HRESP,
  output logic [31:0]       HRDATA,
  input  logic              ERR_CLR,
  output logic              ERR_IRQ,
  output logic [CNT_W-1:0]  ERR_CNT,
  output logic [ADDR_W-1:0] ERR_ADDR,
  output logic              ERR_WRITE
);
  localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);
  state_t state, nxt, acc_st;
  logic [3:0] wcnt;
  logic accept, err_evt, unused;
  assign accept = HSEL & HREADY & HTRANS[1] & HREADYOUT;
  assign acc_st = WAIT_STATES > 0 ? ST_WAIT : RESP_MODE == 0 ? ST_ERR1 : ST_IDLE;
  // HREADYOUT is only high in IDLE/ERR2/DONE, so acceptance can only happen there
  always_comb
    nxt = state == ST_WAIT ? (wcnt == 4'd0 ? (RESP_MODE == 0 ? ST_ERR1 : ST_DONE) : ST_WAIT)
        : state == ST_ERR1 ? ST_ERR2
        : accept ? acc_st : ST_IDLE;
  assign err_evt = nxt == ST_ERR1;
  assign HRDATA  = '0;
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      state     <= ST_IDLE;
      wcnt      <= 4'd0;
      HREADYOUT <= 1'b1;
      HRESP     <= HRESP_OKAY;
      ERR_CNT   <= '0;
      ERR_IRQ   <= 1'b0;
    end else begin
      state     <= nxt;
      wcnt      <= nxt == ST_WAIT ? (state == ST_WAIT ? wcnt - 4'd1 : WS_LOAD) : 4'd0;
      HREADYOUT <= nxt inside {ST_IDLE, ST_ERR2, ST_DONE};
      HRESP     <= nxt inside {ST_ERR1, ST_ERR2} ? HRESP_ERROR : HRESP_OKAY;
      ERR_CNT   <= err_evt ? (ERR_CLR ? CNT_W'(1) : &ERR_CNT ? ERR_CNT : ERR_CNT + CNT_W'(1))
                 : ERR_CLR ? '0 : ERR_CNT;
      ERR_IRQ   <= err_evt | (ERR_IRQ & ~ERR_CLR);
    end
`ifdef AHB_ERR_SLAVE_CAPTURE_EN
  // in mode 0 every accepted transfer becomes an error event, so capture at acceptance
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      ERR_ADDR  <= '0;
      ERR_WRITE <= 1'b0;
    end else if (accept && RESP_MODE == 0 && (!ERR_IRQ || ERR_CLR)) begin
      ERR_ADDR  <= HADDR;
      ERR_WRITE <= HWRITE;
    end
  assign unused = HTRANS[0];
`else
  assign ERR_ADDR  = '0;
  assign ERR_WRITE = 1'b0;
  assign unused    = ^{HTRANS[0], HADDR, HWRITE};
`endif
endmodule
